store_narrow_unit: RTL and testbench

MEM-stage store formatter for the pipelined core: the write-side counterpart of the load/immediate sign-extension path. Accepts a 32-bit register value, byte address and access size from EX/MEM, narrows it to byte/halfword/word, lane-aligns it into a 32-bit write word with byte enables, and flags values that are not recoverable by sign extension. Registered output with valid/ready handshake toward the data-memory port; optional two-beat splitting of misaligned stores.

---
 rtl/store_narrow_unit_pkg.sv | 28 ++
 rtl/store_narrow_unit_lane_align.sv | 52 +++++
 rtl/store_narrow_unit.sv | 160 ++++++++++++++++
 tb/tb_store_narrow_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/store_narrow_unit_pkg.sv
// Shared definitions for the store formatter: size encodings, FSM states, byte-enable masks.
package store_narrow_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_NONE = 4'b0000;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } stateT;

    function automatic logic [3:0] sizeMask(input logic [1:0] size);
        case (size)
            SZ_BYTE: sizeMask = BE_BYTE;
            SZ_HALF: sizeMask = BE_HALF;
            SZ_WORD: sizeMask = BE_WORD;
            default: sizeMask = BE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/store_narrow_unit_lane_align.sv
// Narrows a store value to its access size, lane-shifts it across a 64-bit (two-word) window
// and reports truncation, illegal size and whether the access spills into the next word.
// Purely combinational: zero latency, no backpressure.
module store_narrow_unit_lane_align
    import store_narrow_unit_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    output logic [31:0] wdataLo,
    output logic [31:0] wdataHi,
    output logic [3:0]  beLo,
    output logic [3:0]  beHi,
    output logic        trunc,
    output logic        illegal,
    output logic        misaligned
);

    logic [31:0] narrowed;
    logic [63:0] shifted;
    logic [7:0]  maskWide;
    logic [5:0]  shiftAmt;

    always_comb begin
        narrowed = 32'h0;
        trunc    = 1'b0;
        illegal  = 1'b0;
        case (size)
            SZ_BYTE: begin
                narrowed = {24'h0, data[7:0]};
                trunc    = data[31:8] != {24{data[7]}};
            end
            SZ_HALF: begin
                narrowed = {16'h0, data[15:0]};
                trunc    = data[31:16] != {16{data[15]}};
            end
            SZ_WORD: narrowed = data;
            default: illegal  = 1'b1;
        endcase
    end

    // Bytes shifted past lane 3 land in the upper word, which becomes the second beat.
    assign shiftAmt   = {1'b0, offset, 3'b000};
    assign shifted    = {32'h0, narrowed} << shiftAmt;
    assign maskWide   = {4'h0, sizeMask(size)} << offset;
    assign wdataLo    = shifted[31:0];
    assign wdataHi    = shifted[63:32];
    assign beLo       = maskWide[3:0];
    assign beHi       = maskWide[7:4];
    assign misaligned = |maskWide[7:4];

endmodule

// File: rtl/store_narrow_unit.sv
// MEM-stage store formatter: narrows, lane-aligns and byte-enables a store; STORE_SPLIT_EN splits misaligned stores into two beats.
// Latency 1 cycle from accept to out_*; misaligned split stores take two output beats.
// in_ready drops while the output register is stalled or a second beat is pending; outputs hold while stalled.
module store_narrow_unit
    import store_narrow_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [1:0]        in_size,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_wdata,
    output logic [3:0]        out_be,
    output logic              out_trunc,
    output logic              out_err,
    output logic              out_last
);

    logic [31:0]       alignLo;
    logic [31:0]       alignHi;
    logic [3:0]        beLo;
    logic [3:0]        beHi;
    logic              alignTrunc;
    logic              alignIllegal;
    logic              alignMisaligned;
    logic              accept;
    logic              advance;
    logic              loadSecond;
    logic              misErr;
    logic [ADDR_W-1:0] wordAddr;

    store_narrow_unit_lane_align uAlign (
        .data       (in_data),
        .size       (in_size),
        .offset     (in_addr[1:0]),
        .wdataLo    (alignLo),
        .wdataHi    (alignHi),
        .beLo       (beLo),
        .beHi       (beHi),
        .trunc      (alignTrunc),
        .illegal    (alignIllegal),
        .misaligned (alignMisaligned)
    );

    assign accept   = in_valid && in_ready;
    assign advance  = out_valid && out_ready;
    assign wordAddr = {in_addr[ADDR_W-1:2], 2'b00};

`ifdef STORE_SPLIT_EN
    stateT             state;
    stateT             stateNext;
    logic [ADDR_W-1:0] pendAddr;
    logic [31:0]       pendWdata;
    logic [3:0]        pendBe;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept && alignMisaligned) stateNext = SECOND;
            SECOND:  if (advance) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Second beat is captured alongside the first so the request inputs may change afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pendAddr  <= '0;
            pendWdata <= 32'h0;
            pendBe    <= 4'h0;
        end else if (accept) begin
            pendAddr  <= wordAddr + ADDR_W'(4);
            pendWdata <= alignHi;
            pendBe    <= beHi;
        end
    end

    assign in_ready   = (state == IDLE) && (!out_valid || out_ready);
    assign loadSecond = (state == SECOND) && advance;
    assign misErr     = 1'b0;
`else
    logic unusedHi;

    assign unusedHi   = ^{alignHi, beHi};
    assign in_ready   = !out_valid || out_ready;
    assign loadSecond = 1'b0;
    assign misErr     = alignMisaligned;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_wdata <= 32'h0;
            out_be    <= 4'h0;
            out_trunc <= 1'b0;
            out_err   <= 1'b0;
            out_last  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_addr  <= wordAddr;
            out_trunc <= alignTrunc;
            if (alignIllegal || misErr) begin
                out_err   <= 1'b1;
                out_be    <= 4'h0;
                out_wdata <= 32'h0;
                out_last  <= 1'b1;
            end else begin
                out_err   <= 1'b0;
                out_be    <= beLo;
                out_wdata <= alignLo;
                out_last  <= !alignMisaligned;
            end
        end else if (loadSecond) begin
            out_valid <= 1'b1;
            out_addr  <= pendAddr_or_zero();
            out_wdata <= pendWdata_or_zero();
            out_be    <= pendBe_or_zero();
            out_last  <= 1'b1;
        end else if (advance) begin
            out_valid <= 1'b0;
        end
    end

    // Thin accessors keep the shared output register free of build-specific references.
`ifdef STORE_SPLIT_EN
    function automatic logic [ADDR_W-1:0] pendAddr_or_zero();
        return pendAddr;
    endfunction
    function automatic logic [31:0] pendWdata_or_zero();
        return pendWdata;
    endfunction
    function automatic logic [3:0] pendBe_or_zero();
        return pendBe;
    endfunction
`else
    function automatic logic [ADDR_W-1:0] pendAddr_or_zero();
        return '0;
    endfunction
    function automatic logic [31:0] pendWdata_or_zero();
        return 32'h0;
    endfunction
    function automatic logic [3:0] pendBe_or_zero();
        return 4'h0;
    endfunction
`endif

endmodule

// File: tb/tb_store_narrow_unit.sv
// Directed, table-driven bench for store_narrow_unit; expectations follow STORE_SPLIT_EN when defined.
module tb_store_narrow_unit;
    import store_narrow_unit_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] in_addr;
    logic [1:0]  in_size;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_wdata;
    logic [3:0]  out_be;
    logic        out_trunc;
    logic        out_err;
    logic        out_last;

    int passCount = 0;
    int totalCount = 0;

    store_narrow_unit #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_addr   (in_addr),
        .in_size   (in_size),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_wdata (out_wdata),
        .out_be    (out_be),
        .out_trunc (out_trunc),
        .out_err   (out_err),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] expAddr;
        logic [31:0] expWdata;
        logic [3:0]  expBe;
        logic        expTrunc;
        logic        expErr;
    } vecT;

    vecT vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCount++;
        if (act === exp) passCount++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendOne(input logic [31:0] d, input logic [31:0] a, input logic [1:0] s);
        in_valid = 1'b1;
        in_data  = d;
        in_addr  = a;
        in_size  = s;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic checkBeat(input string tag, input logic [31:0] a, input logic [31:0] w,
                             input logic [3:0] be, input logic tr, input logic er, input logic last);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".addr"},  out_addr, a);
        check({tag, ".wdata"}, out_wdata, w);
        check({tag, ".be"},    32'(out_be), 32'(be));
        check({tag, ".trunc"}, 32'(out_trunc), 32'(tr));
        check({tag, ".err"},   32'(out_err), 32'(er));
        check({tag, ".last"},  32'(out_last), 32'(last));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        in_addr   = 32'h0;
        in_size   = SZ_BYTE;
        out_ready = 1'b1;

        vecs[0] = '{32'h0000_007F, 32'h0000_0103, SZ_BYTE, 32'h0000_0100, 32'h7F00_0000, 4'b1000, 1'b0, 1'b0};
        vecs[1] = '{32'h0001_8000, 32'h0000_0202, SZ_HALF, 32'h0000_0200, 32'h8000_0000, 4'b1100, 1'b1, 1'b0};
        vecs[2] = '{32'h1234_5678, 32'h0000_0400, SZ_WORD, 32'h0000_0400, 32'h1234_5678, 4'b1111, 1'b0, 1'b0};
        vecs[3] = '{32'hFFFF_FF80, 32'h0000_0001, SZ_BYTE, 32'h0000_0000, 32'h0000_8000, 4'b0010, 1'b0, 1'b0};
        vecs[4] = '{32'h0000_0080, 32'h0000_0002, SZ_BYTE, 32'h0000_0000, 32'h0080_0000, 4'b0100, 1'b1, 1'b0};
        vecs[5] = '{32'hDEAD_BEEF, 32'h0000_0502, SZ_ILL,  32'h0000_0500, 32'h0000_0000, 4'b0000, 1'b0, 1'b1};
        vecs[6] = '{32'hFFFF_7FFF, 32'h0000_0600, SZ_HALF, 32'h0000_0600, 32'h0000_7FFF, 4'b0011, 1'b1, 1'b0};
        vecs[7] = '{32'hFFFF_8001, 32'h0000_0000, SZ_HALF, 32'h0000_0000, 32'h0000_8001, 4'b0011, 1'b0, 1'b0};

        // Reset state
        tick();
        tick();
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.addr",  out_addr, 32'h0);
        check("rst.wdata", out_wdata, 32'h0);
        check("rst.be",    32'(out_be), 32'd0);
        check("rst.flags", {29'h0, out_trunc, out_err, out_last}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst.in_ready", 32'(in_ready), 32'd1);

        // Single-beat vector table at full throughput
        for (int i = 0; i < 8; i++) begin
            sendOne(vecs[i].data, vecs[i].addr, vecs[i].size);
            checkBeat($sformatf("vec%0d", i), vecs[i].expAddr, vecs[i].expWdata, vecs[i].expBe,
                      vecs[i].expTrunc, vecs[i].expErr, 1'b1);
        end
        tick();
        check("vec.drain", 32'(out_valid), 32'd0);

        // Back-to-back aligned words with out_ready toggling 1010
        begin
            int sent = 0;
            int got = 0;
            logic stalled = 1'b0;
            logic [31:0] heldW = 32'h0;
            logic [31:0] heldA = 32'h0;
            logic [3:0]  heldBe = 4'h0;
            for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
                in_valid  = (sent < 4);
                in_data   = 32'h1111_0000 + 32'(sent);
                in_addr   = 32'h0000_0700 + 32'(4 * sent);
                in_size   = SZ_WORD;
                out_ready = (cyc % 2 == 0);
                #3;
                if (stalled) begin
                    check("b2b.hold_wdata", out_wdata, heldW);
                    check("b2b.hold_addr",  out_addr, heldA);
                    check("b2b.hold_be",    32'(out_be), 32'(heldBe));
                end
                if (out_valid && out_ready) begin
                    check($sformatf("b2b.wdata%0d", got), out_wdata, 32'h1111_0000 + 32'(got));
                    check($sformatf("b2b.addr%0d", got),  out_addr, 32'h0000_0700 + 32'(4 * got));
                    got++;
                end
                stalled = out_valid && !out_ready;
                heldW   = out_wdata;
                heldA   = out_addr;
                heldBe  = out_be;
                if (in_valid && in_ready) sent++;
                tick();
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            check("b2b.received", 32'(got), 32'd4);
            check("b2b.sent", 32'(sent), 32'd4);
            tick();
            check("b2b.no_dup", 32'(out_valid), 32'd0);
        end

        // Misaligned word at 0x301
        out_ready = 1'b1;
        check("mis.pre_ready", 32'(in_ready), 32'd1);
        sendOne(32'hAABB_CCDD, 32'h0000_0301, SZ_WORD);
`ifdef STORE_SPLIT_EN
        checkBeat("mis.b1", 32'h0000_0300, 32'hBBCC_DD00, 4'b1110, 1'b0, 1'b0, 1'b0);
        check("mis.in_ready_b1", 32'(in_ready), 32'd0);
        tick();
        checkBeat("mis.b2", 32'h0000_0304, 32'h0000_00AA, 4'b0001, 1'b0, 1'b0, 1'b1);
`else
        checkBeat("mis.err", 32'h0000_0300, 32'h0000_0000, 4'b0000, 1'b0, 1'b1, 1'b1);
`endif
        tick();
        check("mis.drain", 32'(out_valid), 32'd0);

        // Halfword at the top of the address space
        sendOne(32'h0000_1234, 32'hFFFF_FFFF, SZ_HALF);
`ifdef STORE_SPLIT_EN
        checkBeat("wrap.b1", 32'hFFFF_FFFC, 32'h3400_0000, 4'b1000, 1'b0, 1'b0, 1'b0);
        tick();
        checkBeat("wrap.b2", 32'h0000_0000, 32'h0000_0012, 4'b0001, 1'b0, 1'b0, 1'b1);
`else
        checkBeat("wrap.err", 32'hFFFF_FFFC, 32'h0000_0000, 4'b0000, 1'b0, 1'b1, 1'b1);
`endif
        tick();
        check("wrap.drain", 32'(out_valid), 32'd0);

        // Reset while the first beat is stalled
        out_ready = 1'b0;
        sendOne(32'h0000_1234, 32'hFFFF_FFFF, SZ_HALF);
        tick();
        check("rstmid.stall_valid", 32'(out_valid), 32'd1);
`ifdef STORE_SPLIT_EN
        check("rstmid.stall_wdata", out_wdata, 32'h3400_0000);
        check("rstmid.stall_last",  32'(out_last), 32'd0);
`else
        check("rstmid.stall_err", 32'(out_err), 32'd1);
`endif
        check("rstmid.stall_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        tick();
        check("rstmid.valid", 32'(out_valid), 32'd0);
        check("rstmid.addr",  out_addr, 32'h0);
        check("rstmid.wdata", out_wdata, 32'h0);
        check("rstmid.be",    32'(out_be), 32'd0);
        check("rstmid.flags", {29'h0, out_trunc, out_err, out_last}, 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        check("rstmid.no_beat2", 32'(out_valid), 32'd0);
        check("rstmid.in_ready", 32'(in_ready), 32'd1);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
